gates_sequencer: RTL and testbench

Self-test controller for the six-function two-input gate block (Z = {XNOR, XOR, NOR, OR, NAND, AND}).
- On a start pulse it drives the gate inputs A/B through all four truth-table vectors and waits a programmable settle time per vector.
- At the end of each settle window it captures the 6-bit gate output and compares it against the hard-wired expected truth table.
- It reports pass/fail, a per-vector error mask and the raw captured words.
- It sits between the lab top-level (buttons/LEDs or testbench) and the combinational gate block, and owns that block's inputs.

---
 rtl/gates_sequencer.sv | 92 +++++++++
 tb/tb_gates_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gates_sequencer.sv
// gates_sequencer: self-test controller that walks the two-input gate block through its truth table.
module gates_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [5:0]  gate_z,
    output logic        gate_a,
    output logic        gate_b,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  err_mask,
    output logic [23:0] capt
);
    localparam logic [23:0] EXP_Z  = 24'h9565AA;
    localparam logic [7:0]  SETTLE = 8'(SETTLE_CYCLES);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q;
    logic [1:0]  idx_q;
    logic [7:0]  cnt_q;
    logic        gate_a_q, gate_b_q, busy_q, done_q, pass_q;
    logic [3:0]  err_q, err_d;
    logic [23:0] capt_q, capt_d;
    always_comb begin
        err_d = err_q;
        capt_d = capt_q;
        err_d[idx_q] = err_q[idx_q] | (gate_z != EXP_Z[6*idx_q +: 6]);
        capt_d[6*idx_q +: 6] = gate_z;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= 8'd0;
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 4'h0;
            capt_q   <= 24'h0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start && !abort) begin
                    state_q  <= RUN;
                    idx_q    <= 2'd0;
                    cnt_q    <= SETTLE;
                    gate_a_q <= 1'b0;
                    gate_b_q <= 1'b0;
                    busy_q   <= 1'b1;
                    err_q    <= 4'h0;
                    capt_q   <= 24'h0;
                end
                RUN: if (abort) begin
                    state_q  <= IDLE;
                    gate_a_q <= 1'b0;
                    gate_b_q <= 1'b0;
                    busy_q   <= 1'b0;
                end else if (cnt_q == 8'd1) begin
                    capt_q <= capt_d;
                    err_q  <= err_d;
                    if (idx_q == 2'd3) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        pass_q   <= (err_d == 4'h0);
                        gate_a_q <= 1'b0;
                        gate_b_q <= 1'b0;
                    end else begin
                        idx_q                  <= idx_q + 2'd1;
                        {gate_a_q, gate_b_q}   <= idx_q + 2'd1;
                        cnt_q                  <= SETTLE;
                    end
                end else begin
                    cnt_q <= cnt_q - 8'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign gate_a   = gate_a_q;
    assign gate_b   = gate_b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_mask = err_q;
    assign capt     = capt_q;
endmodule

// File: tb/tb_gates_sequencer.sv
// tb_gates_sequencer: table-driven and randomized checks of gates_sequencer against a gate-block model.
module tb_gates_sequencer;
    localparam int S = 2;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, start1 = 1'b0;
    logic [5:0]  gate_z, gate_z1;
    logic        gate_a, gate_b, busy, done, pass;
    logic        gate_a1, gate_b1, busy1, done1, pass1;
    logic [3:0]  err_mask, err1;
    logic [23:0] capt, capt1;
    logic [5:0]  and_m = 6'h3F, or_m = 6'h00;
    logic [5:0]  corr [4] = '{default: 6'h00};
    int          chk_n = 0, fail_n = 0;

    typedef struct {
        logic [5:0]  and_m, or_m;
        logic        pass;
        logic [3:0]  err;
        logic [23:0] capt;
    } vec_t;
    vec_t tbl [5];

    always #5 clk = ~clk;

    function automatic logic [5:0] good(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b};
    endfunction

    // Gate block model with stuck-at masks and per-vector corruption
    always_comb gate_z = ((good(gate_a, gate_b) & and_m) | or_m) ^ corr[{gate_a, gate_b}];
    assign gate_z1 = good(gate_a1, gate_b1);

    gates_sequencer #(.SETTLE_CYCLES(S)) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_z(gate_z),
        .gate_a(gate_a), .gate_b(gate_b), .busy(busy), .done(done), .pass(pass),
        .err_mask(err_mask), .capt(capt)
    );
    gates_sequencer #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .gate_z(gate_z1),
        .gate_a(gate_a1), .gate_b(gate_b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_mask(err1), .capt(capt1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic full_run(input logic ep, input logic [3:0] ee, input logic [23:0] ec);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4*S; k++) begin
            chk("run_seq", {busy, done, gate_a, gate_b}, {2'b10, 2'(k / S)});
            @(negedge clk);
        end
        chk("done_pulse", {busy, done, gate_a, gate_b}, 4'b0100);
        chk("pass", pass, ep);
        chk("err_mask", err_mask, ee);
        chk("capt", capt, ec);
        @(negedge clk);
        chk("done_end", {busy, done}, 2'b00);
    endtask

    task automatic held(input bit sel, input int s);
        int ts[$];
        if (sel) start1 = 1'b1; else start = 1'b1;
        for (int c = 0; c < 200 && ts.size() < 2; c++) begin
            @(negedge clk);
            if (sel ? done1 : done) ts.push_back(c);
        end
        start = 1'b0;
        start1 = 1'b0;
        chk("held_done_count", ts.size(), 2);
        if (ts.size() == 2) begin
            chk("held_first_done", ts[0], 4*s);
            chk("held_spacing", ts[1] - ts[0], 4*s + 2);
        end
        repeat (4*s + 4) @(negedge clk);
    endtask

    initial begin
        logic [23:0] ec;
        logic [3:0]  ee;
        logic        p;
        int          nd;
        tbl[0] = '{6'h3F, 6'h00, 1'b1, 4'b0000, 24'h9565AA};
        tbl[1] = '{6'h2F, 6'h00, 1'b0, 4'b0110, 24'h9461AA};
        tbl[2] = '{6'h3F, 6'h01, 1'b0, 4'b0111, 24'h9575EB};
        tbl[3] = '{6'h1F, 6'h00, 1'b0, 4'b1001, 24'h15658A};
        tbl[4] = '{6'h00, 6'h00, 1'b0, 4'b1111, 24'h000000};

        repeat (2) @(negedge clk);
        chk("reset_outputs", {gate_a, gate_b, busy, done, pass, err_mask, capt}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            and_m = tbl[i].and_m;
            or_m  = tbl[i].or_m;
            full_run(tbl[i].pass, tbl[i].err, tbl[i].capt);
        end
        and_m = 6'h3F;
        or_m  = 6'h00;

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 4; i++) corr[i] = ($urandom % 2 == 0) ? 6'($urandom) : 6'h00;
            for (int i = 0; i < 4; i++) begin
                ec[6*i +: 6] = good(i[1], i[0]) ^ corr[i];
                ee[i] = (corr[i] != 6'h00);
            end
            repeat ($urandom % 3) @(negedge clk);
            full_run(ee == 4'h0, ee, ec);
        end
        for (int i = 0; i < 4; i++) corr[i] = 6'h00;

        full_run(1'b1, 4'h0, 24'h9565AA);
        corr[0] = 6'h01;
        corr[1] = 6'h01;
        p = pass;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {busy, done, gate_a, gate_b}, 4'b0000);
        chk("abort_err", err_mask, 4'b0001);
        chk("abort_capt", capt, 24'h00002B);
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            nd += int'(done);
            @(negedge clk);
        end
        chk("abort_no_done", nd, 0);
        chk("abort_pass_kept", pass, p);
        corr[0] = 6'h00;
        corr[1] = 6'h00;

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 1'b0);
        @(negedge clk);
        chk("start_abort_busy2", busy, 1'b0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int k = 0; k < 4*S + 10; k++) begin
            start = (k == 3);
            nd += int'(done);
            @(negedge clk);
        end
        start = 1'b0;
        chk("start_while_busy_dones", nd, 1);

        full_run(1'b1, 4'h0, 24'h9565AA);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset", {gate_a, gate_b, busy, done, pass, err_mask, capt}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        full_run(1'b1, 4'h0, 24'h9565AA);

        held(1'b0, S);
        held(1'b1, 1);
        chk("s1_pass", pass1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", chk_n, fail_n);
        $finish;
    end
endmodule
